kong_keys_decoder: RTL and testbench

//  Turns PS/2 set-2 scan-code bytes from the keyboard receiver into the ask_move_* levels consumed by kong_logic.

---
 rtl/kong_keys_decoder.sv | 150 +++++++++++++++
 tb/tb_kong_keys_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/kong_keys_decoder.sv
// PS/2 set-2 scan-code decoder producing the ask_move_* request levels for kong_logic.
// Optional build macro KONG_KEYS_WASD_EN adds W/A/S/D as alternative direction keys.
module kong_keys_decoder #(
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       ask_move_right,
  output logic       ask_move_left,
  output logic       ask_move_up,
  output logic       ask_move_down,
  output logic       ask_move_jump
);

  localparam int CNT_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dec_en, dec_ext, dec_make;

  // Direction vectors are indexed {down, up, left, right}.
  logic [3:0] arrow_hit, wasd_hit;
  logic       space_hit;
  logic [3:0] held_arrow, held_arrow_nxt;
  logic [3:0] held_wasd, held_wasd_nxt;
  logic [3:0] tap, tap_nxt;
  logic       held_jump, held_jump_nxt;
  logic       jump_pending, jump_pending_nxt;
  logic [3:0] dir_p1, dir_nxt;

  always_comb begin
    state_nxt = state;
    dec_en    = 1'b0;
    dec_ext   = 1'b0;
    dec_make  = 1'b0;
    if (kbd_valid) begin
      unique case (state)
        IDLE: begin
          if (kbd_data == 8'hE0)      state_nxt = EXT;
          else if (kbd_data == 8'hF0) state_nxt = BRK;
          else begin
            dec_en   = 1'b1;
            dec_make = 1'b1;
          end
        end
        EXT: begin
          if (kbd_data == 8'hF0)      state_nxt = EXT_BRK;
          else if (kbd_data == 8'hE0) state_nxt = EXT;
          else begin
            dec_en    = 1'b1;
            dec_ext   = 1'b1;
            dec_make  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          dec_en    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          dec_en    = 1'b1;
          dec_ext   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && cnt == CNT_LAST) begin
      // A stale prefix is dropped silently; no key state changes.
      state_nxt = IDLE;
    end
    cnt_nxt = (kbd_valid || state == IDLE || cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  always_comb begin
    arrow_hit = 4'b0000;
    wasd_hit  = 4'b0000;
    space_hit = 1'b0;
    if (dec_en && dec_ext) begin
      unique case (kbd_data)
        8'h74:   arrow_hit = 4'b0001;
        8'h6B:   arrow_hit = 4'b0010;
        8'h75:   arrow_hit = 4'b0100;
        8'h72:   arrow_hit = 4'b1000;
        default: arrow_hit = 4'b0000;
      endcase
    end
    if (dec_en && !dec_ext) begin
      space_hit = (kbd_data == 8'h29);
`ifdef KONG_KEYS_WASD_EN
      unique case (kbd_data)
        8'h23:   wasd_hit = 4'b0001;
        8'h1C:   wasd_hit = 4'b0010;
        8'h1D:   wasd_hit = 4'b0100;
        8'h1B:   wasd_hit = 4'b1000;
        default: wasd_hit = 4'b0000;
      endcase
`endif
    end
  end

  always_comb begin
    held_arrow_nxt   = dec_make ? (held_arrow | arrow_hit) : (held_arrow & ~arrow_hit);
`ifdef KONG_KEYS_WASD_EN
    held_wasd_nxt    = dec_make ? (held_wasd | wasd_hit) : (held_wasd & ~wasd_hit);
`else
    held_wasd_nxt    = 4'b0000;
`endif
    // Frame-strobe clear happens first so a make on the same clock survives into the next frame.
    tap_nxt          = (startOfFrame ? 4'b0000 : tap) | (dec_make ? (arrow_hit | wasd_hit) : 4'b0000);
    jump_pending_nxt = (startOfFrame ? 1'b0 : jump_pending) | (space_hit && dec_make && !held_jump);
    held_jump_nxt    = space_hit ? dec_make : held_jump;
    dir_nxt          = held_arrow_nxt | held_wasd_nxt | tap_nxt;
  end

  // Decode stage boundary: key state and output levels registered together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      cnt          <= '0;
      held_arrow   <= 4'b0000;
      held_wasd    <= 4'b0000;
      tap          <= 4'b0000;
      held_jump    <= 1'b0;
      jump_pending <= 1'b0;
      dir_p1       <= 4'b0000;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      held_arrow   <= held_arrow_nxt;
      held_wasd    <= held_wasd_nxt;
      tap          <= tap_nxt;
      held_jump    <= held_jump_nxt;
      jump_pending <= jump_pending_nxt;
      dir_p1       <= dir_nxt;
    end
  end

  assign ask_move_right = dir_p1[0];
  assign ask_move_left  = dir_p1[1];
  assign ask_move_up    = dir_p1[2];
  assign ask_move_down  = dir_p1[3];
  assign ask_move_jump  = jump_pending;

endmodule

// File: tb/tb_kong_keys_decoder.sv
// Randomized and directed bench for kong_keys_decoder against a key-set reference model.
module tb_kong_keys_decoder;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_valid = 1'b0;
  logic       r_o, l_o, u_o, d_o, j_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kong_keys_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .ask_move_right(r_o), .ask_move_left(l_o), .ask_move_up(u_o),
    .ask_move_down(d_o), .ask_move_jump(j_o)
  );

  // Reference model: pending prefixes, per-physical-key pressed sets, per-direction taps.
  bit m_ext, m_brk;
  int m_gap;
  bit h_arrow[4], h_wasd[4], tap[4];
  bit h_jump, jp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_gap = 0; h_jump = 0; jp = 0;
    for (int i = 0; i < 4; i++) begin
      h_arrow[i] = 0; h_wasd[i] = 0; tap[i] = 0;
    end
  endtask

  task automatic model_key(input logic [7:0] c, input bit ext, input bit make);
    int idx = -1;
    bit w = 0;
    if (ext) begin
      case (c)
        8'h74: idx = 0;
        8'h6B: idx = 1;
        8'h75: idx = 2;
        8'h72: idx = 3;
        default: idx = -1;
      endcase
    end else begin
      if (c == 8'h29) begin
        if (make) begin
          if (!h_jump) jp = 1;
          h_jump = 1;
        end else h_jump = 0;
        return;
      end
`ifdef KONG_KEYS_WASD_EN
      w = 1;
      case (c)
        8'h23: idx = 0;
        8'h1C: idx = 1;
        8'h1D: idx = 2;
        8'h1B: idx = 3;
        default: idx = -1;
      endcase
`endif
    end
    if (idx < 0) return;
    if (make) begin
      if (w) h_wasd[idx] = 1; else h_arrow[idx] = 1;
      tap[idx] = 1;
    end else begin
      if (w) h_wasd[idx] = 0; else h_arrow[idx] = 0;
    end
  endtask

  task automatic model_edge(input bit sof, input bit v, input logic [7:0] dat);
    if (sof) begin
      for (int i = 0; i < 4; i++) tap[i] = 0;
      jp = 0;
    end
    if (v) begin
      m_gap = 0;
      if (m_brk) begin
        model_key(dat, m_ext, 0);
        m_ext = 0; m_brk = 0;
      end else if (dat == 8'hF0) m_brk = 1;
      else if (dat == 8'hE0) m_ext = 1;
      else begin
        model_key(dat, m_ext, 1);
        m_ext = 0;
      end
    end else if (m_ext || m_brk) begin
      m_gap++;
      if (m_gap >= T) begin
        m_ext = 0; m_brk = 0; m_gap = 0;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [4:0] o;
    o[4] = jp;
    for (int i = 0; i < 4; i++) o[i] = h_arrow[i] | h_wasd[i] | tap[i];
    return o;
  endfunction

  task automatic cyc(input string tag, input bit sof, input bit v, input logic [7:0] dat);
    startOfFrame = sof; kbd_valid = v; kbd_data = dat;
    @(posedge clk);
    model_edge(sof, v, dat);
    #1;
    check(tag, {27'd0, j_o, d_o, u_o, l_o, r_o}, {27'd0, model_out()});
    startOfFrame = 1'b0; kbd_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    cyc(tag, 0, 1, b);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 8'h00);
  endtask

  logic [7:0] codes[12];

  initial begin
    codes = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h00};
    model_reset();
    #12;
    check("reset_outs", {27'd0, j_o, d_o, u_o, l_o, r_o}, 32'd0);
    resetN = 1'b1;
    idle("post_reset", 2);

    // Left arrow: make then break, tap holds until frame strobe.
    send("t1_e0", 8'hE0); send("t1_6b", 8'h6B);
    check("t1_left_on", l_o, 1);
    send("t1_e0b", 8'hE0); send("t1_f0", 8'hF0); send("t1_6bb", 8'h6B);
    check("t1_left_tap", l_o, 1);
    idle("t1_idle", 3);
    cyc("t1_sof", 1, 0, 8'h00);
    check("t1_left_off", l_o, 0);

    // Right tapped within one frame.
    send("t2", 8'hE0); send("t2", 8'h74); send("t2", 8'hE0); send("t2", 8'hF0); send("t2", 8'h74);
    check("t2_right_tap", r_o, 1);
    cyc("t2_sof", 1, 0, 8'h00);
    check("t2_right_off", r_o, 0);

    // Jump with typematic repeat, then re-arm, then make on the frame-strobe clock.
    for (int i = 0; i < 5; i++) send("t3_rep", 8'h29);
    check("t3_jump_on", j_o, 1);
    cyc("t3_sof", 1, 0, 8'h00);
    send("t3_rep2", 8'h29);
    check("t3_no_rearm", j_o, 0);
    send("t3_f0", 8'hF0); send("t3_brk", 8'h29);
    send("t3_press2", 8'h29);
    check("t3_rearm", j_o, 1);
    send("t3_f0b", 8'hF0); send("t3_brk2", 8'h29);
    cyc("t3_sof_make", 1, 1, 8'h29);
    check("t3_sof_make_on", j_o, 1);
    idle("t3_frame", 10);
    check("t3_held_frame", j_o, 1);
    cyc("t3_sof2", 1, 0, 8'h00);
    check("t3_off", j_o, 0);
    send("t3_f0c", 8'hF0); send("t3_brk3", 8'h29);

    // Prefix timeout: exactly T idle clocks drops E0, T-1 keeps it.
    send("t4_e0", 8'hE0); idle("t4_wait", T); send("t4_6b", 8'h6B);
    check("t4_dropped", l_o, 0);
    send("t4_e0b", 8'hE0); idle("t4_wait_b", T - 1); send("t4_6b_b", 8'h6B);
    check("t4_kept", l_o, 1);
    send("t4_rel", 8'hE0); send("t4_rel", 8'hF0); send("t4_rel", 8'h6B);
    cyc("t4_sof", 1, 0, 8'h00);

    // Asynchronous reset while up is held, then a stray F0 75.
    send("t5", 8'hE0); send("t5", 8'h75);
    check("t5_up_on", u_o, 1);
    send("t5_e0", 8'hE0);
    #2 resetN = 1'b0;
    #1 check("t5_async_rst", {27'd0, j_o, d_o, u_o, l_o, r_o}, 32'd0);
    model_reset();
    @(posedge clk); #1 resetN = 1'b1;
    send("t5_f0", 8'hF0); send("t5_75", 8'h75);
    check("t5_stays_0", {27'd0, j_o, d_o, u_o, l_o, r_o}, 32'd0);

`ifdef KONG_KEYS_WASD_EN
    send("t6", 8'h1C); send("t6", 8'hE0); send("t6", 8'h6B); send("t6", 8'hF0); send("t6", 8'h1C);
    cyc("t6_sof", 1, 0, 8'h00);
    check("t6_left_kept", l_o, 1);
    send("t6", 8'hE0); send("t6", 8'hF0); send("t6", 8'h6B);
    cyc("t6_sof2", 1, 0, 8'h00);
    check("t6_left_off", l_o, 0);
`else
    send("t6_w", 8'h1D);
    check("t6_wasd_ignored", u_o, 0);
`endif

    // Randomized traffic with periodic frame strobes and occasional long gaps.
    for (int n = 0; n < 3000; n++) begin
      bit sof;
      bit v;
      logic [7:0] b;
      int k;
      sof = (n % 25) == 24;
      v = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 11);
      b = (k == 11) ? 8'($urandom_range(0, 255)) : codes[k];
      cyc("rand", sof, v, b);
      if ($urandom_range(0, 63) == 0) idle("rand_gap", $urandom_range(T - 3, T + 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
